dll_gate_sequencer: RTL

//   Clocked write-side driver for a bank of NUM_LAT active-low-gated latches (D/GN style, transparent while GN=0).

---
 rtl/dll_gate_seq_pkg.sv | 25 ++
 rtl/dll_gate_timer.sv | 28 ++
 rtl/dll_gate_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dll_gate_seq_pkg.sv
// Shared types and sizing helpers for the latch gate sequencer.
// The counter and address widths are derived here so the top and the timer agree.
package dll_gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // The counter only has to hold the largest phase length minus one.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dll_gate_timer.sv
// Loadable down-counter shared by the SETUP, OPEN and HOLD phases.
// It stops at zero, so an idle sequencer never wraps the count.
module dll_gate_timer #(
    parameter int CW = 2
) (
    input  logic          CK,
    input  logic          RN,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dll_gate_sequencer.sv
// Write-side driver for a bank of GN-gated latches: data is set up, one gate is pulsed
// low for a fixed width, data is held, then done pulses. All outputs come from flops.
module dll_gate_sequencer
    import dll_gate_seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_LAT   = 4,
    parameter int SETUP_CYC = 1,
    parameter int WIDTH_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                          CK,
    input  logic                          RN,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [addr_w(NUM_LAT)-1:0]    req_addr,
    input  logic [DATA_W-1:0]             req_data,
    output logic [DATA_W-1:0]             lat_d,
    output logic [NUM_LAT-1:0]            lat_gn,
    output logic                          done,
    output logic                          err,
    output logic [DATA_W*NUM_LAT-1:0]     shadow_q
);

    localparam int AW = addr_w(NUM_LAT);
    localparam int CW = cnt_w(SETUP_CYC, WIDTH_CYC, HOLD_CYC);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] WIDTH_LD = CW'(WIDTH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_t          state, next_state;
    logic [AW-1:0]   addr_q;
    logic            addr_ok;
    logic [NUM_LAT-1:0] gn_open;

    logic            tmr_load;
    logic [CW-1:0]   tmr_ld_val;
    logic            tmr_zero;
    logic            accept, open_gate, close_gate, finish;

    dll_gate_timer #(.CW(CW)) u_timer (
        .CK       (CK),
        .RN       (RN),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_ld_val = '0;
        accept     = 1'b0;
        open_gate  = 1'b0;
        close_gate = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept     = 1'b1;
                tmr_load   = 1'b1;
                tmr_ld_val = SETUP_LD;
                next_state = SETUP;
            end
            SETUP: if (tmr_zero) begin
                open_gate  = 1'b1;
                tmr_load   = 1'b1;
                tmr_ld_val = WIDTH_LD;
                next_state = OPEN;
            end
            OPEN: if (tmr_zero) begin
                close_gate = 1'b1;
                tmr_load   = 1'b1;
                tmr_ld_val = HOLD_LD;
                next_state = HOLD;
            end
            HOLD: if (tmr_zero) begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // An out-of-range index matches no gate, so the whole bank stays closed.
    always_comb begin
        addr_ok = (int'(addr_q) < NUM_LAT);
        for (int i = 0; i < NUM_LAT; i++) begin
            gn_open[i] = (int'(addr_q) != i);
        end
    end

    // NOTE: the shadow array is a plain register bank and is reset, unlike a RAM macro would be.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            req_ready <= 1'b1;
            addr_q    <= '0;
            lat_d     <= '0;
            lat_gn    <= '1;
            done      <= 1'b0;
            err       <= 1'b0;
            shadow_q  <= '0;
        end else begin
            req_ready <= (next_state == IDLE);
            done      <= finish;
            err       <= finish & ~addr_ok;
            if (accept) begin
                addr_q <= req_addr;
                lat_d  <= req_data;
            end
            if (open_gate) begin
                lat_gn <= gn_open;
            end else if (close_gate) begin
                lat_gn <= '1;
            end
            for (int i = 0; i < NUM_LAT; i++) begin
                if (finish && (int'(addr_q) == i)) begin
                    shadow_q[i*DATA_W +: DATA_W] <= lat_d;
                end
            end
        end
    end

endmodule
